// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control unit: FSM states, opcodes and datapath select codes.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_DECODE = 4'd3,
    S_ALU    = 4'd4,
    S_BR     = 4'd5,
    S_JMP    = 4'd6,
    S_LEA    = 4'd7,
    S_ADDR   = 4'd8,
    S_LD1    = 4'd9,
    S_LD2    = 4'd10,
    S_ST1    = 4'd11,
    S_ST2    = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] SELPC_INC = 2'b00;
  localparam logic [1:0] SELPC_EAB = 2'b01;
  localparam logic [1:0] SELPC_BUS = 2'b10;

  localparam logic       EAB1_PC = 1'b0;
  localparam logic       EAB1_RA = 1'b1;

  localparam logic [1:0] EAB2_ZERO = 2'b00;
  localparam logic [1:0] EAB2_OFF6 = 2'b01;
  localparam logic [1:0] EAB2_OFF9 = 2'b10;
  localparam logic [1:0] EAB2_OF11 = 2'b11;

  localparam logic       MAR_EAB  = 1'b0;
  localparam logic       MAR_ZEXT = 1'b1;

  localparam logic       MDR_BUS = 1'b0;
  localparam logic       MDR_MEM = 1'b1;

endpackage

// File: rtl/lc3_decode.sv
// Opcode to first execute state; anything unsupported lands in HALT.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic [3:0] opcode_i,
  output state_e     exec_state_o
);

  always_comb begin
    exec_state_o = S_HALT;
    case (opcode_i)
      OP_ADD, OP_AND, OP_NOT:        exec_state_o = S_ALU;
      OP_BR:                         exec_state_o = S_BR;
      OP_JMP:                        exec_state_o = S_JMP;
      OP_LEA:                        exec_state_o = S_LEA;
      OP_LD, OP_ST, OP_LDR, OP_STR:  exec_state_o = S_ADDR;
      default:                       exec_state_o = S_HALT;
    endcase
  end

endmodule

// File: rtl/lc3_fsm.sv
// LC-3 multicycle control unit: state register plus Moore output decode from state and IR.
// All outputs are forced low while reset is held.
module lc3_fsm
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaMDR,
  output logic        enaPC,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        memWE,
  output logic [1:0]  aluControl,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMAR,
  output logic        selMDR,
  output logic [2:0]  SR0,
  output logic [2:0]  SR1,
  output logic [2:0]  DR,
  output logic [3:0]  state,
  output logic        instrDone,
  output logic        halted
);

  state_e state_q;
  state_e state_d;
  state_e exec_state;
  logic   br_taken;
  logic   unused_ir;

  // Immediate-vs-register ALU forms are resolved inside the ALU, not here.
  assign unused_ir = ^IR[5:3];
  assign br_taken  = |(IR[11:9] & {N, Z, P});

  lc3_decode u_decode (
    .opcode_i     (IR[15:12]),
    .exec_state_o (exec_state)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: state_d = exec_state;
      S_ADDR:   state_d = IR[12] ? S_ST1 : S_LD1;
      S_LD1:    state_d = S_LD2;
      S_ST1:    state_d = S_ST2;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH0;
    else        state_q <= state_d;
  end

  always_comb begin
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    enaMDR     = 1'b0;
    enaPC      = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    regWE      = 1'b0;
    memWE      = 1'b0;
    aluControl = ALU_ADD;
    selPC      = SELPC_INC;
    selEAB1    = EAB1_PC;
    selEAB2    = EAB2_ZERO;
    selMAR     = MAR_EAB;
    selMDR     = MDR_BUS;
    SR0        = 3'd0;
    SR1        = 3'd0;
    DR         = 3'd0;
    state      = S_FETCH0;
    instrDone  = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      state = state_q;
      case (state_q)
        S_FETCH0: begin
          enaPC = 1'b1;
          ldMAR = 1'b1;
          ldPC  = 1'b1;
          selPC = SELPC_INC;
        end
        S_FETCH1: begin
          ldMDR  = 1'b1;
          selMDR = MDR_MEM;
        end
        S_FETCH2: begin
          enaMDR = 1'b1;
          ldIR   = 1'b1;
        end
        S_ALU: begin
          SR0       = IR[8:6];
          SR1       = IR[2:0];
          DR        = IR[11:9];
          enaALU    = 1'b1;
          regWE     = 1'b1;
          instrDone = 1'b1;
          case (IR[15:12])
            OP_AND:  aluControl = ALU_AND;
            OP_NOT:  aluControl = ALU_NOT;
            default: aluControl = ALU_ADD;
          endcase
        end
        S_BR: begin
          selEAB1   = EAB1_PC;
          selEAB2   = EAB2_OFF9;
          selPC     = SELPC_EAB;
          ldPC      = br_taken;
          instrDone = 1'b1;
        end
        S_JMP: begin
          SR0       = IR[8:6];
          selEAB1   = EAB1_RA;
          selEAB2   = EAB2_ZERO;
          selPC     = SELPC_EAB;
          ldPC      = 1'b1;
          instrDone = 1'b1;
        end
        S_LEA: begin
          selEAB1   = EAB1_PC;
          selEAB2   = EAB2_OFF9;
          selMAR    = MAR_EAB;
          enaMARM   = 1'b1;
          DR        = IR[11:9];
          regWE     = 1'b1;
          instrDone = 1'b1;
        end
        S_ADDR: begin
          enaMARM = 1'b1;
          ldMAR   = 1'b1;
          selMAR  = MAR_EAB;
          // LDR/STR (opcode bit 14 set) use base register + offset6.
          if (IR[14]) begin
            selEAB1 = EAB1_RA;
            selEAB2 = EAB2_OFF6;
            SR0     = IR[8:6];
          end else begin
            selEAB1 = EAB1_PC;
            selEAB2 = EAB2_OFF9;
          end
        end
        S_LD1: begin
          ldMDR  = 1'b1;
          selMDR = MDR_MEM;
        end
        S_LD2: begin
          enaMDR    = 1'b1;
          DR        = IR[11:9];
          regWE     = 1'b1;
          instrDone = 1'b1;
        end
        S_ST1: begin
          SR0        = IR[11:9];
          aluControl = ALU_PASS;
          enaALU     = 1'b1;
          ldMDR      = 1'b1;
          selMDR     = MDR_BUS;
        end
        S_ST2: begin
          memWE     = 1'b1;
          instrDone = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_fsm.sv
// Bench for lc3_fsm: per-instruction cycle-indexed reference model, directed and random instructions.
module tb_lc3_fsm;

  typedef struct packed {
    logic       ena_alu, ena_marm, ena_mdr, ena_pc;
    logic       ld_pc, ld_ir, ld_mar, ld_mdr, reg_we, mem_we;
    logic [1:0] alu;
    logic [1:0] sel_pc;
    logic       eab1;
    logic [1:0] eab2;
    logic       sel_mar, sel_mdr;
    logic [2:0] sr0, sr1, dr;
    logic [3:0] st;
    logic       done, halted;
  } vec_t;

  logic        clk, reset;
  logic [15:0] IR;
  logic        N, Z, P;
  logic        enaALU, enaMARM, enaMDR, enaPC, ldPC, ldIR, ldMAR, ldMDR, regWE, memWE;
  logic [1:0]  aluControl, selPC, selEAB2;
  logic        selEAB1, selMAR, selMDR;
  logic [2:0]  SR0, SR1, DR;
  logic [3:0]  state;
  logic        instrDone, halted;

  int n_checks = 0;
  int n_pass   = 0;
  bit inv_en   = 1'b0;

  lc3_fsm dut (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P),
    .enaALU(enaALU), .enaMARM(enaMARM), .enaMDR(enaMDR), .enaPC(enaPC),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .regWE(regWE), .memWE(memWE), .aluControl(aluControl), .selPC(selPC),
    .selEAB1(selEAB1), .selEAB2(selEAB2), .selMAR(selMAR), .selMDR(selMDR),
    .SR0(SR0), .SR1(SR1), .DR(DR), .state(state),
    .instrDone(instrDone), .halted(halted)
  );

  vec_t dut_v;
  assign dut_v = {enaALU, enaMARM, enaMDR, enaPC, ldPC, ldIR, ldMAR, ldMDR, regWE, memWE,
                  aluControl, selPC, selEAB1, selEAB2, selMAR, selMDR, SR0, SR1, DR,
                  state, instrDone, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit is_mem(input logic [3:0] op);
    return op == 4'h2 || op == 4'h3 || op == 4'h6 || op == 4'h7;
  endfunction

  function automatic int ncyc(input logic [15:0] ir);
    logic [3:0] op = ir[15:12];
    if (is_mem(op)) return 7;
    if (op == 4'h1 || op == 4'h5 || op == 4'h9 || op == 4'h0 || op == 4'hC || op == 4'hE) return 5;
    return 0;
  endfunction

  // Expected outputs in cycle k (0-based) of executing instruction ir.
  function automatic vec_t model(input logic [15:0] ir, input logic n, z, p, input int k);
    vec_t v = '0;
    logic [3:0] op = ir[15:12];
    if (k == 0) begin
      v.st = 0; v.ena_pc = 1; v.ld_mar = 1; v.ld_pc = 1;
    end else if (k == 1) begin
      v.st = 1; v.ld_mdr = 1; v.sel_mdr = 1;
    end else if (k == 2) begin
      v.st = 2; v.ena_mdr = 1; v.ld_ir = 1;
    end else if (k == 3) begin
      v.st = 3;
    end else if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      v.st = 4; v.sr0 = ir[8:6]; v.sr1 = ir[2:0]; v.dr = ir[11:9];
      v.ena_alu = 1; v.reg_we = 1; v.done = 1;
      v.alu = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
    end else if (op == 4'h0) begin
      v.st = 5; v.eab2 = 2; v.sel_pc = 1; v.done = 1;
      v.ld_pc = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    end else if (op == 4'hC) begin
      v.st = 6; v.sr0 = ir[8:6]; v.eab1 = 1; v.sel_pc = 1; v.ld_pc = 1; v.done = 1;
    end else if (op == 4'hE) begin
      v.st = 7; v.eab2 = 2; v.ena_marm = 1; v.dr = ir[11:9]; v.reg_we = 1; v.done = 1;
    end else if (is_mem(op)) begin
      bit store = (op == 4'h3 || op == 4'h7);
      bit based = (op == 4'h6 || op == 4'h7);
      if (k == 4) begin
        v.st = 8; v.ena_marm = 1; v.ld_mar = 1;
        if (based) begin v.eab1 = 1; v.eab2 = 1; v.sr0 = ir[8:6]; end
        else v.eab2 = 2;
      end else if (k == 5) begin
        if (store) begin
          v.st = 11; v.sr0 = ir[11:9]; v.alu = 3; v.ena_alu = 1; v.ld_mdr = 1;
        end else begin
          v.st = 9; v.ld_mdr = 1; v.sel_mdr = 1;
        end
      end else begin
        if (store) begin v.st = 12; v.mem_we = 1; v.done = 1; end
        else begin v.st = 10; v.ena_mdr = 1; v.dr = ir[11:9]; v.reg_we = 1; v.done = 1; end
      end
    end else begin
      v.st = 13; v.halted = 1;
    end
    return v;
  endfunction

  // Entered just after a falling edge; leaves at the falling edge following the last cycle.
  task automatic run_instr(input logic [15:0] ir, input logic n, z, p, input int cycles);
    int nc = (cycles > 0) ? cycles : ncyc(ir);
    IR = ir; N = n; Z = z; P = p;
    for (int k = 0; k < nc; k++) begin
      #1;
      check($sformatf("instr %h cyc%0d", ir, k), dut_v, model(ir, n, z, p, k));
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      #1;
      check("bus_onehot", 64'($countones({enaALU, enaMARM, enaMDR, enaPC}) <= 1), 64'd1);
    end
  end

  initial begin
    vec_t m;
    logic [3:0] ops [10];
    logic [15:0] ir;
    ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'hE, 4'h2, 4'h3, 4'h6, 4'h7};

    // Pin the reference model against hand-computed values.
    m = model(16'h0000, 0, 0, 0, 0);
    check("pin_fetch0", {m.ena_pc, m.ld_mar, m.ld_pc, m.sel_pc, m.st}, {3'b111, 2'd0, 4'd0});
    m = model(16'h1283, 0, 0, 0, 4);
    check("pin_add", {m.dr, m.sr0, m.sr1, m.alu, m.ena_alu, m.reg_we, m.done},
          {3'd1, 3'd2, 3'd3, 2'd0, 3'b111});
    m = model(16'h0405, 0, 1, 0, 4);
    check("pin_brz_taken", {m.ld_pc, m.sel_pc, m.eab2}, {1'b1, 2'd1, 2'd2});
    m = model(16'h0405, 1, 0, 1, 4);
    check("pin_brz_not", {m.ld_pc, m.sel_pc}, {1'b0, 2'd1});
    m = model(16'h6443, 0, 0, 0, 4);
    check("pin_ldr_addr", {m.eab1, m.eab2, m.sr0, m.st}, {1'b1, 2'd1, 3'd1, 4'd8});
    m = model(16'h6443, 0, 0, 0, 6);
    check("pin_ldr_ld2", {m.dr, m.reg_we, m.done}, {3'd2, 2'b11});
    m = model(16'h3A02, 0, 0, 0, 5);
    check("pin_st1", {m.sr0, m.alu, m.ld_mdr, m.sel_mdr}, {3'd5, 2'd3, 1'b1, 1'b0});
    m = model(16'h3A02, 0, 0, 0, 6);
    check("pin_st2", {m.mem_we, m.done}, 2'b11);
    m = model(16'hF025, 0, 0, 0, 20);
    check("pin_halt", {m.halted, m.st}, {1'b1, 4'd13});
    check("pin_lat_ldr", 64'(ncyc(16'h6443)), 64'd7);
    check("pin_lat_add", 64'(ncyc(16'h1283)), 64'd5);

    // Reset held: everything gated to zero.
    reset = 1'b0; IR = 16'h1283; N = 0; Z = 0; P = 0;
    #1 check("reset_t0", dut_v, 64'd0);
    repeat (2) @(negedge clk);
    #1 check("reset_held", dut_v, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    inv_en = 1'b1;

    run_instr(16'h1283, 0, 0, 0, 0);
    run_instr(16'h0405, 0, 1, 0, 0);
    run_instr(16'h0405, 0, 0, 0, 0);
    run_instr(16'h0E05, 0, 0, 0, 0);
    run_instr(16'h0005, 1, 1, 1, 0);
    run_instr(16'h6443, 0, 0, 0, 0);
    run_instr(16'h3A02, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      ir = 16'($urandom);
      ir[15:12] = ops[$urandom_range(9)];
      run_instr(ir, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    // Reset in the middle of LD1 abandons the load.
    run_instr(16'h2403, 0, 0, 0, 5);
    #1 check("ld1_before_reset", dut_v, model(16'h2403, 0, 0, 0, 5));
    #1 reset = 1'b0;
    #1 check("reset_mid_ld1", dut_v, 64'd0);
    @(posedge clk);
    #2 check("reset_mid_ld1_hold", dut_v, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(16'h2403, 0, 0, 0, 0);

    // TRAP falls into HALT and stays for 20 cycles.
    run_instr(16'hF025, 0, 0, 0, 24);
    #1 reset = 1'b0;
    #1 check("reset_from_halt", dut_v, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(16'h1283, 0, 0, 0, 0);
    run_instr(16'h0000, 1, 1, 1, 0);

    inv_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
